tile_stream_partitioner: RTL and testbench
==========================================

# tile_stream_partitioner

Streaming successor to the single-cycle partitioner. It accepts matrices A and B as row-major element streams and buffers both in internal register files. It then emits square tiles of TILE_DIM x TILE_DIM, zero-padded at the edges, over a valid/ready stream tagged with the destination PIM unit. It sits between the host loader and the PIM dispatch fabric, and supports any matrix size from 1 to MAX_MATRIX_SIZE and any unit count.

## Interface
- DATA_WIDTH, 32, element width
- MAX_MATRIX_SIZE, 16, largest accepted n
- TILE_DIM, 8, maximum tile edge (one PIM unit's capacity)
- NUM_PIM_UNITS, 4, number of destination units; tiles are assigned round-robin
- clk  in  1  single clock; everything is on its rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid / cfg_ready  in/out  1  job-start handshake
- cfg_matrix_size  in  SIZE_W = $clog2(MAX_MATRIX_SIZE+1)  n
- cfg_err  out  1  one-cycle pulse: n rejected
- in_valid / in_ready  in/out  1  element input handshake
- in_data  in  DATA_WIDTH  element; all of A row-major, then all of B row-major
- out_valid / out_ready  out/in  1  tile output handshake
- out_data  out  DATA_WIDTH  tile element
- out_unit  out  UNIT_W = max(1,$clog2(NUM_PIM_UNITS))  destination unit
- out_is_b  out  1  0 = A block, 1 = B block
- out_row, out_col  out  TILE_W = max(1,$clog2(TILE_DIM))  position inside the tile
- out_last  out  1  last beat of the B block of a tile
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: job complete

## Operation
- Derived values:
  - eff = min(n, TILE_DIM)
  - tpd = ceil(n/eff)
  - tiles = tpd²
- Tile t covers block (t / tpd, t % tpd) and goes to unit t % NUM_PIM_UNITS.
- Per tile, the block emits eff² A beats, then eff² B beats, both row-major.
- A global index (br·eff+row, bc·eff+col) that is ≥ n emits data 0. This is the edge padding.
- IDLE:
  - cfg_ready=1.
  - A cfg handshake with 1 ≤ n ≤ MAX_MATRIX_SIZE latches n and goes to LOAD_A.
  - Any other n pulses cfg_err next cycle and stays in IDLE.
- LOAD_A:
  - in_ready=1.
  - Each handshake writes mem_A[r][c] and advances (r,c).
  - After the n²-th element, go to LOAD_B.
- LOAD_B:
  - Same as LOAD_A, into mem_B.
  - After the n²-th element, go to EMIT.
- EMIT:
  - Counters: tile, sel (A/B), row, col.
  - After the handshake that carries out_last of tile tiles-1, go to IDLE and pulse done.
- Memory locations outside n×n are never read, so stale contents are harmless.
- in_valid while in_ready=0 is ignored. cfg_valid outside IDLE is ignored; no error.

## Timing
- Reset values:
  - state IDLE, all counters 0.
  - cfg_ready=1, in_ready=0, out_valid=0, cfg_err=0, done=0, busy=0.
  - out_data/out_unit/out_is_b/out_row/out_col/out_last all 0.
- Reset mid-job: the next cycle is IDLE, the partial job is discarded, and no done pulse is produced.
- Input rate: 1 element per cycle; in_ready depends only on state.
- Output registers:
  - Memory read is combinational into the registered out_* fields.
  - The registers load when !out_valid || out_ready.
  - Sustains 1 beat per cycle with no bubbles between A/B blocks or between tiles.
- The first out_valid appears in the cycle after the final B handshake.
- While out_valid && !out_ready, every out_* field holds stable.
- done is asserted in the cycle after the final output handshake, and cfg_ready=1 in that same cycle.
- Minimum job latency, cfg handshake to done: 1 + 2n² + 2·tiles·eff² + 1 cycles.
- Sizing: n² ≤ MAX_MATRIX_SIZE², so the element counters need $clog2(MAX_MATRIX_SIZE²+1) bits.

## Structure
- Package tsp_pkg holds:
  - the state enum (IDLE, LOAD_A, LOAD_B, EMIT);
  - the width functions SIZE_W, TILE_W, UNIT_W;
  - the tile-geometry helper function (eff, tpd).
- One sub-module, tsp_matrix_store: a MAX_MATRIX_SIZE² register file with one write port and one combinational read port. It is instantiated twice, for A and B.

## Test plan
- n=4, TILE_DIM=8, A[i][j]=i·4+j, B[i][j]=100+i·4+j:
  - One tile to unit 0: 16 A beats, then 16 B beats.
  - out_last on beat 32, with data 115.
  - done is asserted one cycle later.
- n=16, NUM_PIM_UNITS=4:
  - Tiles 0–3 go to units 0,1,2,3.
  - Tile 1, A beat (0,0) carries A[0][8].
  - 512 output beats in total, with out_ready held high and no bubbles.
- n=12, TILE_DIM=8:
  - eff=8, tpd=2.
  - Tile 3, A beat (row 4, col 0) is 0 (global index 12 is padding).
  - Tile 3, A beat (0,0) carries A[8][8].
- n=16, NUM_PIM_UNITS=2: tile 2 goes to unit 0, tile 3 to unit 1.
- Deassert out_ready for 5 cycles mid-tile:
  - out_data, out_row and out_col stay constant.
  - No beat is lost or duplicated.
- cfg_matrix_size=0, then 17:
  - cfg_err pulses each time and busy stays 0.
  - Then assert rst in EMIT: outputs return to their reset values and done never pulses.

Source files
------------

// File: rtl/tile_stream_partitioner_pkg.sv
// Shared types and geometry helpers for the streaming tile partitioner.
// eff is the tile edge actually used, tpd the number of tiles along one edge.
package tsp_pkg;

   typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, EMIT} tsp_state_e;

   typedef struct packed {
      int eff;
      int tpd;
   } tile_geom_t;

   function automatic int size_w(input int max_n);
      return $clog2(max_n + 1);
   endfunction

   function automatic int tile_w(input int tile_dim);
      return (tile_dim > 1) ? $clog2(tile_dim) : 1;
   endfunction

   function automatic int unit_w(input int num_units);
      return (num_units > 1) ? $clog2(num_units) : 1;
   endfunction

   // Small matrices form a single tile of edge n, so the only divide is by a constant.
   function automatic tile_geom_t tile_geom(input int n, input int tile_dim);
      tile_geom_t g;
      if (n <= tile_dim) begin
         g.eff = n;
         g.tpd = 1;
      end else begin
         g.eff = tile_dim;
         g.tpd = (n + tile_dim - 1) / tile_dim;
      end
      return g;
   endfunction

endpackage

// File: rtl/tile_stream_partitioner_if.sv
// Config, element-input and tile-output streams of the partitioner.
// slave is the partitioner side, master the host/fabric side.
interface tsp_if
   import tsp_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_MATRIX_SIZE = 16,
   parameter int TILE_DIM        = 8,
   parameter int NUM_PIM_UNITS   = 4
);
   localparam int SIZE_W = size_w(MAX_MATRIX_SIZE);
   localparam int TILE_W = tile_w(TILE_DIM);
   localparam int UNIT_W = unit_w(NUM_PIM_UNITS);

   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [SIZE_W-1:0]     cfg_matrix_size;
   logic                  cfg_err;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [UNIT_W-1:0]     out_unit;
   logic                  out_is_b;
   logic [TILE_W-1:0]     out_row;
   logic [TILE_W-1:0]     out_col;
   logic                  out_last;
   logic                  busy;
   logic                  done;

   modport slave (
      input  cfg_valid, cfg_matrix_size, in_valid, in_data, out_ready,
      output cfg_ready, cfg_err, in_ready, out_valid, out_data, out_unit,
             out_is_b, out_row, out_col, out_last, busy, done
   );

   modport master (
      output cfg_valid, cfg_matrix_size, in_valid, in_data, out_ready,
      input  cfg_ready, cfg_err, in_ready, out_valid, out_data, out_unit,
             out_is_b, out_row, out_col, out_last, busy, done
   );
endinterface

// File: rtl/tile_stream_partitioner_store.sv
// Matrix register file: one synchronous write port, one combinational read port.
module tsp_matrix_store #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/tile_stream_partitioner.sv
// Buffers A and B row-major, then streams zero-padded TILE_DIM tiles
// (A block then B block per tile) round-robin across PIM units.
module tile_stream_partitioner
   import tsp_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_MATRIX_SIZE = 16,
   parameter int TILE_DIM        = 8,
   parameter int NUM_PIM_UNITS   = 4
) (
   input logic clk,
   input logic rst,
   tsp_if.slave bus
);
   localparam int SIZE_W = size_w(MAX_MATRIX_SIZE);
   localparam int TILE_W = tile_w(TILE_DIM);
   localparam int UNIT_W = unit_w(NUM_PIM_UNITS);
   localparam int DEPTH  = MAX_MATRIX_SIZE * MAX_MATRIX_SIZE;
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int GW     = SIZE_W + 1;

   tsp_state_e            state;
   logic [SIZE_W-1:0]     n_q, eff_q, tpd_q;
   logic [SIZE_W-1:0]     ld_r, ld_c;
   logic [SIZE_W-1:0]     br, bc, rb, cb;
   logic [TILE_W-1:0]     row, col;
   logic                  sel, gen_done;
   logic [UNIT_W-1:0]     unit;
   logic                  cfg_ready_q, in_ready_q, busy_q, cfg_err_q, done_q;
   logic                  out_valid_q, out_is_b_q, out_last_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [UNIT_W-1:0]     out_unit_q;
   logic [TILE_W-1:0]     out_row_q, out_col_q;

   tile_geom_t            geom;
   logic [GW-1:0]         gr, gc;
   logic                  pad, in_hs, ld_last, col_end, row_end, bc_end, br_end, emit_load;
   logic [AW-1:0]         waddr, raddr;
   logic [DATA_WIDTH-1:0] rd_a, rd_b, beat_data;

   assign geom      = tile_geom(int'(bus.cfg_matrix_size), TILE_DIM);
   assign gr        = GW'(rb) + GW'(row);
   assign gc        = GW'(cb) + GW'(col);
   assign pad       = (gr >= GW'(n_q)) || (gc >= GW'(n_q));
   assign raddr     = AW'(int'(gr) * MAX_MATRIX_SIZE + int'(gc));
   assign waddr     = AW'(int'(ld_r) * MAX_MATRIX_SIZE + int'(ld_c));
   assign in_hs     = bus.in_valid && in_ready_q;
   assign ld_last   = (ld_r == n_q - SIZE_W'(1)) && (ld_c == n_q - SIZE_W'(1));
   assign col_end   = SIZE_W'(col) == eff_q - SIZE_W'(1);
   assign row_end   = SIZE_W'(row) == eff_q - SIZE_W'(1);
   assign bc_end    = bc == tpd_q - SIZE_W'(1);
   assign br_end    = br == tpd_q - SIZE_W'(1);
   assign beat_data = pad ? '0 : (sel ? rd_b : rd_a);

   // The first A beat is loaded on the final B write so the stream starts with no gap.
   assign emit_load = (state == EMIT && !gen_done && (!out_valid_q || bus.out_ready)) ||
                      (state == LOAD_B && in_hs && ld_last);

   tsp_matrix_store #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_store_a (
      .clk(clk), .we(state == LOAD_A && in_hs), .waddr(waddr), .wdata(bus.in_data),
      .raddr(raddr), .rdata(rd_a)
   );

   tsp_matrix_store #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_store_b (
      .clk(clk), .we(state == LOAD_B && in_hs), .waddr(waddr), .wdata(bus.in_data),
      .raddr(raddr), .rdata(rd_b)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         n_q <= '0; eff_q <= '0; tpd_q <= '0;
         ld_r <= '0; ld_c <= '0;
         br <= '0; bc <= '0; rb <= '0; cb <= '0;
         row <= '0; col <= '0; sel <= 1'b0; unit <= '0; gen_done <= 1'b0;
         cfg_ready_q <= 1'b1; in_ready_q <= 1'b0; busy_q <= 1'b0;
         cfg_err_q <= 1'b0; done_q <= 1'b0;
         out_valid_q <= 1'b0; out_data_q <= '0; out_unit_q <= '0;
         out_is_b_q <= 1'b0; out_row_q <= '0; out_col_q <= '0; out_last_q <= 1'b0;
      end else begin
         cfg_err_q <= 1'b0;
         done_q    <= 1'b0;
         case (state)
            IDLE: if (bus.cfg_valid) begin
               if (bus.cfg_matrix_size != '0 &&
                   bus.cfg_matrix_size <= SIZE_W'(MAX_MATRIX_SIZE)) begin
                  n_q   <= bus.cfg_matrix_size;
                  eff_q <= SIZE_W'(geom.eff);
                  tpd_q <= SIZE_W'(geom.tpd);
                  ld_r <= '0; ld_c <= '0;
                  br <= '0; bc <= '0; rb <= '0; cb <= '0;
                  row <= '0; col <= '0; sel <= 1'b0; unit <= '0; gen_done <= 1'b0;
                  cfg_ready_q <= 1'b0; in_ready_q <= 1'b1; busy_q <= 1'b1;
                  state <= LOAD_A;
               end else begin
                  cfg_err_q <= 1'b1;
               end
            end
            LOAD_A, LOAD_B: if (in_hs) begin
               if (ld_last) begin
                  ld_r <= '0;
                  ld_c <= '0;
                  if (state == LOAD_A) begin
                     state <= LOAD_B;
                  end else begin
                     state      <= EMIT;
                     in_ready_q <= 1'b0;
                  end
               end else if (ld_c == n_q - SIZE_W'(1)) begin
                  ld_c <= '0;
                  ld_r <= ld_r + SIZE_W'(1);
               end else begin
                  ld_c <= ld_c + SIZE_W'(1);
               end
            end
            EMIT: if (out_valid_q && bus.out_ready && gen_done) begin
               state       <= IDLE;
               done_q      <= 1'b1;
               cfg_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: state <= IDLE;
         endcase

         if (emit_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= beat_data;
            out_unit_q  <= unit;
            out_is_b_q  <= sel;
            out_row_q   <= row;
            out_col_q   <= col;
            out_last_q  <= sel && row_end && col_end;
            // Advance col -> row -> A/B block -> tile (bc, then br).
            if (!col_end) col <= col + TILE_W'(1);
            else begin
               col <= '0;
               if (!row_end) row <= row + TILE_W'(1);
               else begin
                  row <= '0;
                  if (!sel) sel <= 1'b1;
                  else begin
                     sel  <= 1'b0;
                     unit <= (unit == UNIT_W'(NUM_PIM_UNITS - 1)) ? '0 : unit + UNIT_W'(1);
                     if (!bc_end) begin
                        bc <= bc + SIZE_W'(1);
                        cb <= cb + eff_q;
                     end else begin
                        bc <= '0;
                        cb <= '0;
                        if (!br_end) begin
                           br <= br + SIZE_W'(1);
                           rb <= rb + eff_q;
                        end else begin
                           gen_done <= 1'b1;
                        end
                     end
                  end
               end
            end
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.cfg_ready = cfg_ready_q;
   assign bus.cfg_err   = cfg_err_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_unit  = out_unit_q;
   assign bus.out_is_b  = out_is_b_q;
   assign bus.out_row   = out_row_q;
   assign bus.out_col   = out_col_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_tile_stream_partitioner.sv
// Job table driven against a reference tile model; beats are scoreboarded and
// a second instance with two units checks the round-robin assignment.
module tb_tile_stream_partitioner;
   localparam int DW   = 32;
   localparam int MAXN = 16;
   localparam int TD   = 8;
   localparam int NU   = 4;
   localparam int SW   = $clog2(MAXN + 1);
   localparam int FW   = DW + 2 + 1 + 3 + 3 + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tsp_if #(.DATA_WIDTH(DW), .MAX_MATRIX_SIZE(MAXN), .TILE_DIM(TD), .NUM_PIM_UNITS(NU)) bus ();
   tsp_if #(.DATA_WIDTH(DW), .MAX_MATRIX_SIZE(MAXN), .TILE_DIM(TD), .NUM_PIM_UNITS(2)) bus2 ();

   tile_stream_partitioner #(.DATA_WIDTH(DW), .MAX_MATRIX_SIZE(MAXN), .TILE_DIM(TD),
                             .NUM_PIM_UNITS(NU)) dut (.clk(clk), .rst(rst), .bus(bus));
   tile_stream_partitioner #(.DATA_WIDTH(DW), .MAX_MATRIX_SIZE(MAXN), .TILE_DIM(TD),
                             .NUM_PIM_UNITS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   assign bus2.cfg_valid       = bus.cfg_valid;
   assign bus2.cfg_matrix_size = bus.cfg_matrix_size;
   assign bus2.in_valid        = bus.in_valid;
   assign bus2.in_data         = bus.in_data;
   assign bus2.out_ready       = bus.out_ready;

   typedef struct {
      int n; bit err; int mode; int b_base; int beats;
   } vec_t;
   typedef struct {
      logic [DW-1:0] data; int unit; bit is_b; int row; int col; bit last; int tile;
   } beat_t;

   beat_t          sb_q[$];
   vec_t           vecs[11];
   int             tests = 0, fails = 0, cyc = 0;
   int             beats, first_cyc, last_cyc;
   bit             mon_en = 1'b1, prev_stall, done_exp;
   logic [FW-1:0]  prev_f;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [FW-1:0] pack_exp(input beat_t e);
      return {e.data, 2'(e.unit), e.is_b, 3'(e.row), 3'(e.col), e.last};
   endfunction

   function automatic logic [FW-1:0] out_fields();
      return {bus.out_data, bus.out_unit, bus.out_is_b, bus.out_row, bus.out_col, bus.out_last};
   endfunction

   task automatic push_expected(input vec_t v);
      int eff, tpd, gr, gc;
      beat_t e;
      eff = (v.n < TD) ? v.n : TD;
      tpd = (v.n + eff - 1) / eff;
      for (int t = 0; t < tpd * tpd; t++)
         for (int s = 0; s < 2; s++)
            for (int r = 0; r < eff; r++)
               for (int c = 0; c < eff; c++) begin
                  gr = (t / tpd) * eff + r;
                  gc = (t % tpd) * eff + c;
                  e.data = (gr < v.n && gc < v.n) ? DW'((s != 0 ? v.b_base : 0) + gr * v.n + gc) : '0;
                  e.unit = t % NU;  e.is_b = (s != 0); e.row = r; e.col = c;
                  e.last = (s != 0) && r == eff - 1 && c == eff - 1;
                  e.tile = t;
                  sb_q.push_back(e);
               end
   endtask

   task automatic at_neg();
      logic [FW-1:0] f;
      beat_t e;
      @(negedge clk);
      cyc++;
      if (mon_en) begin
         f = out_fields();
         if (prev_stall) chk("stall_hold", f, prev_f);
         chk("done", bus.done, done_exp);
         if (bus.done) begin
            chk("done_cfg_ready", bus.cfg_ready, 1);
            chk("done_busy", bus.busy, 0);
         end
         done_exp = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL extra_beat: got %0h with nothing expected", f);
            end else begin
               e = sb_q.pop_front();
               chk("beat", f, pack_exp(e));
               chk("unit_2units", bus2.out_unit, e.tile % 2);
               if (sb_q.size() == 0) done_exp = 1'b1;
            end
            beats++;
            if (beats == 1) first_cyc = cyc;
            last_cyc = cyc;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_f = f;
      end
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string name);
      chk(name, {bus.cfg_ready, bus.in_ready, bus.out_valid, bus.cfg_err, bus.done, bus.busy,
                 out_fields()}, {6'b100000, {FW{1'b0}}});
   endtask

   task automatic run_job(input vec_t v, input bit abort);
      int idx, n2, dc;
      bit acc, fin;
      beats = 0; done_exp = 1'b0; prev_stall = 1'b0;
      if (!v.err) push_expected(v);
      bus.cfg_matrix_size = SW'(v.n);
      bus.cfg_valid = 1'b1;
      at_neg();
      chk("cfg_ready_idle", bus.cfg_ready, 1);
      to_pos();
      bus.cfg_valid = 1'b0;
      if (v.err) begin
         at_neg();
         chk("cfg_err_pulse", bus.cfg_err, 1);
         chk("err_busy", bus.busy, 0);
         to_pos();
         at_neg();
         chk("cfg_err_clear", bus.cfg_err, 0);
         chk("err_busy_after", bus.busy, 0);
         to_pos();
         return;
      end
      // cfg_valid with an illegal size during the job must be ignored silently.
      bus.cfg_valid = 1'b1;
      bus.cfg_matrix_size = '0;
      idx = 0; n2 = v.n * v.n; dc = 0;
      while (idx < 2 * n2 && dc < 4000) begin
         bus.in_valid = (v.mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.in_data  = (idx < n2) ? DW'(idx) : DW'(v.b_base + idx - n2);
         at_neg();
         chk("load_no_cfg_err", bus.cfg_err, 0);
         chk("load_no_out", bus.out_valid, 0);
         acc = bus.in_valid && bus.in_ready;
         to_pos();
         if (acc) idx++;
         dc++;
      end
      bus.in_valid = 1'b0;
      bus.cfg_valid = 1'b0;
      if (idx < 2 * n2) begin
         tests++; fails++;
         $display("FAIL load_timeout: got %0d elements accepted, required %0d", idx, 2 * n2);
      end
      if (abort) begin
         mon_en = 1'b0;
         bus.out_ready = 1'b0;
         at_neg();
         chk("emit_busy", bus.busy, 1);
         chk("emit_valid", bus.out_valid, 1);
         to_pos();
         rst = 1'b1;
         to_pos();
         rst = 1'b0;
         at_neg();
         check_reset_state("reset_mid_emit");
         to_pos();
         bus.out_ready = 1'b1;
         for (int k = 0; k < 8; k++) begin
            at_neg();
            chk("abort_no_done", bus.done, 0);
            chk("abort_idle", {bus.out_valid, bus.busy, bus.cfg_ready}, 3'b001);
            to_pos();
         end
         sb_q.delete();
         mon_en = 1'b1;
         return;
      end
      dc = 0; fin = 1'b0;
      while (!fin && dc < 4000) begin
         case (v.mode)
            1:       bus.out_ready = !(dc >= 20 && dc < 25);
            2:       bus.out_ready = ($urandom_range(0, 2) != 0);
            default: bus.out_ready = 1'b1;
         endcase
         at_neg();
         if (dc == 0) chk("first_valid", bus.out_valid, 1);
         fin = bus.done;
         to_pos();
         dc++;
      end
      if (!fin) begin
         tests++; fails++;
         $display("FAIL done_timeout: got no done after %0d cycles", dc);
      end
      chk("beat_count", beats, v.beats);
      chk("sb_empty", sb_q.size(), 0);
      if (v.mode == 0) chk("no_bubble", last_cyc - first_cyc, v.beats - 1);
      sb_q.delete();
   endtask

   initial begin
      bus.cfg_valid = 1'b0; bus.cfg_matrix_size = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      // {n, err, ready mode (0 steady, 1 five-cycle stall, 2 random), B base, beats}
      vecs[0]  = '{4,  0, 0, 100,  32};
      vecs[1]  = '{16, 0, 0, 1000, 512};
      vecs[2]  = '{12, 0, 0, 1000, 512};
      vecs[3]  = '{16, 0, 1, 2000, 512};
      vecs[4]  = '{1,  0, 2, 50,   2};
      vecs[5]  = '{9,  0, 2, 500,  512};
      vecs[6]  = '{5,  0, 0, 100,  50};
      vecs[7]  = '{0,  1, 0, 0,    0};
      vecs[8]  = '{17, 1, 0, 0,    0};
      vecs[9]  = '{4,  0, 0, 100,  32};
      vecs[10] = '{3,  0, 0, 300,  18};
      mon_en = 1'b0;
      to_pos();
      to_pos();
      at_neg();
      check_reset_state("reset_values");
      to_pos();
      rst = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < 11; i++) run_job(vecs[i], i == 9);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
